// File: rtl/multi_flop_sync.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module      : multi_flop_sync
// Description : Multi-flop level synchronizer for WIDTH independent bits
//               crossing into the dst_clk domain.
//               Optional edge-detect outputs are enabled by the
//               MULTI_FLOP_SYNC_EDGE_DET_EN macro.
//               When the macro is undefined, the rise and fall pulse ports are
//               tied low and no history flops are built.
// Parameters  : STAGES    - flops per bit in the synchronizer chain (2..8)
//               WIDTH     - number of independent bits
//               RESET_VAL - value loaded into every stage on reset
// Ports       : dst_clk    - destination clock (rising edge)
//               dst_rst    - synchronous active-high reset
//               async_data - asynchronous input bits
//               sync_data  - synchronized bits (output of the last stage)
//               sync_valid - high once the chain holds only post-reset samples
//               rise_pulse - one-cycle pulse on a 0->1 change of sync_data
//               fall_pulse - one-cycle pulse on a 1->0 change of sync_data
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module multi_flop_sync #(
    parameter int               STAGES    = 2,
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             dst_clk,
    input  logic             dst_rst,
    input  logic [WIDTH-1:0] async_data,
    output logic [WIDTH-1:0] sync_data,
    output logic             sync_valid,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    // Counter only needs to reach STAGES-1; the valid flag covers the last step.
    localparam int               CNT_W      = $clog2(STAGES);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STAGES - 1);

    // Synchronizer chain: index 0 samples async_data, index STAGES-1 drives
    // sync_data. Pure flop-to-flop path, nothing in between.
    logic [STAGES-1:0][WIDTH-1:0] r_stage;
    logic [CNT_W-1:0]             r_cnt;
    logic                         r_valid;

    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            r_stage <= {STAGES{RESET_VAL}};
        end else begin
            r_stage <= {r_stage[STAGES-2:0], async_data};
        end
    end

    // sync_valid rises on the STAGES-th edge after reset release: by then every
    // stage has been refilled from async_data.
    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (!r_valid) begin
            if (r_cnt == c_cnt_last) begin
                r_valid <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign sync_data  = r_stage[STAGES-1];
    assign sync_valid = r_valid;

`ifdef MULTI_FLOP_SYNC_EDGE_DET_EN
    // History holds the previous sync_data value, so each pulse lasts exactly
    // the first cycle in which sync_data shows its new value.
    logic [WIDTH-1:0] r_hist;

    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            r_hist <= RESET_VAL;
        end else begin
            r_hist <= r_stage[STAGES-1];
        end
    end

    // Pulses are masked until the chain is fully post-reset.
    assign rise_pulse = {WIDTH{r_valid}} & sync_data  & ~r_hist;
    assign fall_pulse = {WIDTH{r_valid}} & ~sync_data &  r_hist;
`else
    assign rise_pulse = '0;
    assign fall_pulse = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_flop_sync.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_multi_flop_sync
// Description : Self-checking bench for multi_flop_sync (STAGES=2, WIDTH=1,
//               RESET_VAL=0). It combines timed directed scenarios, a
//               per-cycle vector table and randomized toggles. A reference
//               model built from per-edge sample history checks every cycle.
//               Works with and without MULTI_FLOP_SYNC_EDGE_DET_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_multi_flop_sync;

    localparam int STAGES = 2;
    localparam int MAXE   = 1024;
`ifdef MULTI_FLOP_SYNC_EDGE_DET_EN
    localparam logic EDGE = 1'b1;
`else
    localparam logic EDGE = 1'b0;
`endif

    logic dst_clk;
    logic dst_rst;
    logic async_data;
    logic sync_data;
    logic sync_valid;
    logic rise_pulse;
    logic fall_pulse;

    int total = 0;
    int bad   = 0;

    multi_flop_sync #(
        .STAGES   (STAGES),
        .WIDTH    (1),
        .RESET_VAL(1'b0)
    ) dut (
        .dst_clk   (dst_clk),
        .dst_rst   (dst_rst),
        .async_data(async_data),
        .sync_data (sync_data),
        .sync_valid(sync_valid),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    initial begin
        dst_clk = 1'b0;
        forever #5 dst_clk = ~dst_clk;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
        end
    endtask

    //--------------------------------------------------------------------------
    // Reference model: record what the DUT sees at every rising edge, then
    // derive expected outputs from that history.
    //--------------------------------------------------------------------------
    logic samp [MAXE];
    logic rstv [MAXE];
    int   n = 0;

    always @(posedge dst_clk) begin
        if (n < MAXE) begin
            samp[n] <= async_data;
            rstv[n] <= dst_rst;
            n       <= n + 1;
        end
    end

    // Output after edge m equals the input sampled STAGES-1 edges earlier.
    // It is the reset value if any edge in that window was a reset edge.
    function automatic logic m_sync(input int m);
        for (int j = 0; j < STAGES; j++) begin
            if (m - j < 0) return 1'b0;
            if (rstv[m-j]) return 1'b0;
        end
        return samp[m-STAGES+1];
    endfunction

    function automatic logic m_valid(input int m);
        int run = 0;
        for (int j = m; j >= 0 && run < STAGES; j--) begin
            if (rstv[j]) break;
            run++;
        end
        return (run >= STAGES);
    endfunction

    always @(negedge dst_clk) begin
        if (n >= 1 && n < MAXE) begin
            logic v, s, p;
            v = m_valid(n - 1);
            s = m_sync(n - 1);
            p = (n >= 2) ? m_sync(n - 2) : 1'b0;
            chk("model_sync",  {31'd0, sync_data},  {31'd0, s});
            chk("model_valid", {31'd0, sync_valid}, {31'd0, v});
            chk("model_rise",  {31'd0, rise_pulse}, {31'd0, EDGE & v &  s & ~p});
            chk("model_fall",  {31'd0, fall_pulse}, {31'd0, EDGE & v & ~s &  p});
        end
    end

    //--------------------------------------------------------------------------
    // Timing helpers: each scenario starts at a base aligned to a falling edge,
    // so its rising edges fall at base+5, base+15, ...
    //--------------------------------------------------------------------------
    time base;

    task automatic start_scn();
        base = (($time / 10) + 1) * 10;
    endtask

    task automatic at(input time rel);
        #(base + rel - $time);
    endtask

    task automatic chk_out(input string nm, input logic s, input logic v,
                           input logic r, input logic f);
        chk({nm, "_sync"},  {31'd0, sync_data},  {31'd0, s});
        chk({nm, "_valid"}, {31'd0, sync_valid}, {31'd0, v});
        chk({nm, "_rise"},  {31'd0, rise_pulse}, {31'd0, r});
        chk({nm, "_fall"},  {31'd0, fall_pulse}, {31'd0, f});
    endtask

    typedef struct {
        logic rst;
        logic din;
        logic e_sync;
        logic e_valid;
        logic e_rise;
        logic e_fall;
    } vec_t;

    vec_t vt [14];

    initial begin
        time t;
        dst_rst    = 1'b1;
        async_data = 1'b0;

        // Per-cycle vectors: inputs applied before an edge, outputs after it.
        // Rise and fall entries give edge-detect behavior and are masked
        // when edge detection is compiled out.
        vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset with async_data held high throughout.
        base = 0;
        dst_rst = 1'b1; async_data = 1'b1;
        at(10); chk_out("rst_e5",  1'b0, 1'b0, 1'b0, 1'b0);
        at(16); chk_out("rst_e15", 1'b0, 1'b0, 1'b0, 1'b0);
        at(20); dst_rst = 1'b0;
        at(26); chk_out("rst_e25", 1'b0, 1'b0, 1'b0, 1'b0);
        at(36); chk_out("rst_e35", 1'b1, 1'b1, EDGE, 1'b0);

        // Latency and fall.
        start_scn();
        at(0);  dst_rst = 1'b1; async_data = 1'b0;
        at(20); dst_rst = 1'b0;
        at(27); async_data = 1'b1;
        at(36); chk_out("lat_e35", 1'b0, 1'b1, 1'b0, 1'b0);
        at(40); async_data = 1'b0;
        at(46); chk_out("lat_e45", 1'b1, 1'b1, EDGE, 1'b0);
        at(56); chk_out("fall_e55", 1'b0, 1'b1, 1'b0, EDGE);
        at(66); chk_out("fall_e65", 1'b0, 1'b1, 1'b0, 1'b0);

        // Narrow pulse that spans no rising edge.
        start_scn();
        at(0);  dst_rst = 1'b1; async_data = 1'b0;
        at(20); dst_rst = 1'b0;
        at(46); async_data = 1'b1;
        at(49); async_data = 1'b0;
        at(56); chk_out("narrow_e55", 1'b0, 1'b1, 1'b0, 1'b0);
        at(66); chk_out("narrow_e65", 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset asserted while a rising level is in flight.
        start_scn();
        at(0);  dst_rst = 1'b1; async_data = 1'b0;
        at(20); dst_rst = 1'b0;
        at(27); async_data = 1'b1;
        at(30); dst_rst = 1'b1;
        at(36); chk_out("midrst_e35", 1'b0, 1'b0, 1'b0, 1'b0);
        at(40); dst_rst = 1'b0;
        at(46); chk_out("midrst_e45", 1'b0, 1'b0, 1'b0, 1'b0);
        at(56); chk_out("midrst_e55", 1'b1, 1'b1, EDGE, 1'b0);

        // Vector table.
        for (int i = 0; i < 14; i++) begin
            @(negedge dst_clk);
            dst_rst    = vt[i].rst;
            async_data = vt[i].din;
            @(posedge dst_clk);
            #1;
            chk_out($sformatf("vec%0d", i), vt[i].e_sync, vt[i].e_valid,
                    EDGE & vt[i].e_rise, EDGE & vt[i].e_fall);
        end

        // Random toggles at 3..15 ns intervals; the model checks every cycle.
        start_scn();
        at(0);  dst_rst = 1'b1; async_data = 1'($urandom_range(0, 1));
        at(20); dst_rst = 1'b0;
        t = 30;
        for (int k = 0; k < 10; k++) begin
            t = t + time'($urandom_range(3, 15));
            if ((t % 10) == 5) t = t + 1;
            at(t);
            async_data = ~async_data;
        end
        at(t + 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
